// File: rtl/sig_mon_pkg.sv
// Shared types and default addresses for the
// signature capture monitor and its bench.
package sig_mon_pkg;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } mon_state_t;

  localparam logic [31:0] DEF_SIG_BASE  = 32'h0000_0F00;
  localparam logic [31:0] DEF_HALT_ADDR = 32'hCAFE_BEEF;
  localparam int          DEF_TIMEOUT   = 500000;

endpackage

// File: rtl/sig_fifo.sv
// Show-ahead synchronous FIFO; pointers carry an
// extra MSB so full/empty differ on wrap.
module sig_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // a pop frees the slot, so full+pop+push is accepted
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sig_capture_monitor.sv
// Store-port snooper: captures signature-window
// stores, ends the run on halt store or watchdog.
module sig_capture_monitor
  import sig_mon_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] SIG_BASE  = ADDR_W'(DEF_SIG_BASE),
  parameter int                SIG_BYTES = 4,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(DEF_HALT_ADDR),
  parameter int                DEPTH     = 16,
  parameter int                TIMEOUT   = DEF_TIMEOUT,
  parameter int                CNT_W     = $clog2(TIMEOUT+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [DATA_W-1:0] sig_data,
  output logic [ADDR_W-1:0] sig_offset,
  output logic [15:0]       sig_count,
  output logic [CNT_W-1:0]  cycles,
  output logic              halt,
  output logic              timeout,
  output logic              overflow,
  output logic              done
);

  localparam logic [ADDR_W:0] WIN_LO = {1'b0, SIG_BASE};
  localparam logic [ADDR_W:0] WIN_HI =
    WIN_LO + (ADDR_W+1)'(SIG_BYTES);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT-1);

  mon_state_t state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [15:0] cnt_q, cnt_d;
  logic halt_q, halt_d;
  logic to_q, to_d;
  logic ovf_q, ovf_d;

  logic [ADDR_W:0] addr_x;
  logic [ADDR_W-1:0] offs;
  logic [ADDR_W+DATA_W-1:0] head;
  logic run, in_win, is_halt;
  logic cap, hlt, wd, pop;
  logic full, empty;

  // widened compare so the window end cannot wrap
  assign addr_x  = {1'b0, st_addr};
  assign in_win  = (addr_x >= WIN_LO) && (addr_x < WIN_HI);
  assign is_halt = (st_addr == HALT_ADDR);
  assign run     = (state_q == S_RUN);

  assign cap = run & st_valid & in_win & ~is_halt;
  assign hlt = run & st_valid & is_halt;
  assign wd  = run & (cyc_q == WD_LAST);
  assign pop = sig_valid & sig_ready;
  assign offs = st_addr - SIG_BASE;

  sig_fifo #(
    .WIDTH (ADDR_W+DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (cap),
    .pop_i   (pop),
    .wdata_i ({offs, st_data}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (hlt | wd) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    cyc_d  = cyc_q;
    cnt_d  = cnt_q;
    halt_d = halt_q | hlt;
    to_d   = to_q | wd;
    ovf_d  = ovf_q | (cap & full & ~pop);
    if (run & ~wd) cyc_d = cyc_q + 1'b1;
    if (cap && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cyc_q   <= '0;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      to_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      to_q    <= to_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sig_valid  = ~empty;
  assign sig_offset = head[ADDR_W+DATA_W-1:DATA_W];
  assign sig_data   = head[DATA_W-1:0];
  assign sig_count  = cnt_q;
  assign cycles     = cyc_q;
  assign halt       = halt_q;
  assign timeout    = to_q;
  assign overflow   = ovf_q;
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sig_capture_monitor.sv
// Directed + random bench for sig_capture_monitor
// against a queue-based run/drain model.
module tb_sig_capture_monitor;
  import sig_mon_pkg::*;

  localparam int          TO    = 100;
  localparam int          DEP   = 4;
  localparam int          BYTES = 16;
  localparam logic [31:0] BASE  = DEF_SIG_BASE;
  localparam logic [31:0] HALTA = DEF_HALT_ADDR;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic        sig_valid, sig_ready;
  logic [31:0] sig_data, sig_offset;
  logic [15:0] sig_count;
  logic [6:0]  cycles;
  logic        halt, timeout, overflow, done;

  sig_capture_monitor #(
    .SIG_BYTES (BYTES),
    .DEPTH     (DEP),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .sig_valid  (sig_valid),
    .sig_ready  (sig_ready),
    .sig_data   (sig_data),
    .sig_offset (sig_offset),
    .sig_count  (sig_count),
    .cycles     (cycles),
    .halt       (halt),
    .timeout    (timeout),
    .overflow   (overflow),
    .done       (done)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  logic [63:0] mq[$];
  int m_cnt, m_cyc;
  bit m_halt, m_to, m_ovf, m_done, m_run;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_cyc = 0;
    m_halt = 0; m_to = 0; m_ovf = 0;
    m_done = 0; m_run = 1;
  endtask

  task automatic check_all();
    chk("valid", 64'(sig_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("data", 64'(sig_data), 64'(mq[0][31:0]));
      chk("offset", 64'(sig_offset), 64'(mq[0][63:32]));
    end
    chk("count", 64'(sig_count), 64'(m_cnt));
    chk("cycles", 64'(cycles), 64'(m_cyc));
    chk("halt", 64'(halt), 64'(m_halt));
    chk("timeout", 64'(timeout), 64'(m_to));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("done", 64'(done), 64'(m_done));
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input bit v, input logic [31:0] a,
                      input logic [31:0] d, input bit rdy);
    bit pop, cap, hlt, wd, ndone;
    st_valid = v; st_addr = a; st_data = d; sig_ready = rdy;
    pop = (mq.size() > 0) && rdy;
    cap = m_run && v && a >= BASE && a < BASE + BYTES &&
          a != HALTA;
    hlt = m_run && v && a == HALTA;
    wd = m_run && m_cyc == TO - 1;
    ndone = m_done || (!m_run && mq.size() == 0);
    if (pop) void'(mq.pop_front());
    if (cap) begin
      if (m_cnt < 65535) m_cnt++;
      if (mq.size() < DEP) mq.push_back({a - BASE, d});
      else m_ovf = 1;
    end
    if (m_run) begin
      if (!wd) m_cyc++;
      if (hlt) m_halt = 1;
      if (wd) m_to = 1;
      if (hlt || wd) m_run = 0;
    end
    m_done = ndone;
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    st_valid = 1'b0; sig_ready = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_run(input int n, input bit allow_halt);
    int r;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 15);
      if (r < 10) a = BASE + 32'(4 * $urandom_range(0, 3));
      else if (r == 10) a = BASE + 32'(BYTES);
      else if (r == 11) a = BASE - 32'd4;
      else if (r == 12 && allow_halt) a = HALTA;
      else if (r == 13) a = BASE + 32'd1;
      else a = $urandom;
      step($urandom_range(0, 3) != 0, a, $urandom,
           $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    st_addr = '0; st_data = '0;
    do_reset();

    // three stores to the base, sink always ready
    step(1, BASE, 32'h11, 1);
    step(1, BASE, 32'h22, 1);
    step(1, BASE, 32'h33, 1);
    step(1, BASE + 32'(BYTES), 32'h44, 1);
    step(1, BASE - 32'd4, 32'h55, 1);
    repeat (3) step(0, '0, '0, 1);
    chk("p1_count", 64'(sig_count), 64'd3);

    // window edges: last word in, first past end out
    do_reset();
    step(1, BASE + 32'h4, 32'hA4, 0);
    step(1, BASE + 32'hC, 32'hAC, 0);
    step(1, BASE + 32'h10, 32'hB0, 0);
    chk("p2_count", 64'(sig_count), 64'd2);
    chk("p2_offs", 64'(sig_offset), 64'd4);
    repeat (3) step(0, '0, '0, 1);

    // fill, full+pop+push, then overflow
    do_reset();
    for (int i = 0; i < 4; i++) step(1, BASE, 32'(i), 0);
    step(1, BASE + 32'h8, 32'h100, 1);
    chk("p3_noovf", 64'(overflow), 64'd0);
    step(1, BASE, 32'h200, 0);
    step(1, BASE, 32'h300, 0);
    chk("p3_ovf", 64'(overflow), 64'd1);
    chk("p3_count", 64'(sig_count), 64'd7);
    repeat (5) step(0, '0, '0, 1);

    // halt with two queued, later stores ignored
    do_reset();
    step(1, BASE, 32'hD1, 0);
    step(1, BASE + 32'h4, 32'hD2, 0);
    step(1, HALTA, 32'hEE, 0);
    step(1, BASE, 32'hD3, 0);
    step(1, HALTA, 32'hEF, 0);
    chk("p4_halt", 64'(halt), 64'd1);
    chk("p4_count", 64'(sig_count), 64'd2);
    repeat (4) step(0, '0, '0, 1);
    chk("p4_done", 64'(done), 64'd1);

    // watchdog with no halt
    do_reset();
    repeat (TO + 2) step(0, '0, '0, 0);
    chk("p5_to", 64'(timeout), 64'd1);
    chk("p5_cyc", 64'(cycles), 64'(TO - 1));
    chk("p5_done", 64'(done), 64'd1);

    // async reset with three entries held
    do_reset();
    for (int i = 0; i < 3; i++) step(1, BASE, 32'(i), 0);
    #2 rst = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk); #1 check_all();
    @(negedge clk); rst = 1'b1;
    step(0, '0, '0, 1);

    for (int s = 0; s < 4; s++) begin
      do_reset();
      rand_run(s == 3 ? 150 : 60, s != 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
